// File: rtl/contadores_ajuste_pkg.sv
// Shared BCD field limits, cursor/group encodings and the days-per-month helper.
// Purely declarative: no state, no latency, no flow control.
package contadores_ajuste_pkg;

  localparam logic [7:0] HORA_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEG_MAX  = 8'h59;
  localparam logic [7:0] DIA_MIN  = 8'h01;
  localparam logic [7:0] DIA_MAX  = 8'h31;
  localparam logic [7:0] MES_MIN  = 8'h01;
  localparam logic [7:0] MES_MAX  = 8'h12;
  localparam logic [7:0] YEAR_MAX = 8'h99;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  typedef enum logic [1:0] {CUR_0 = 2'd0, CUR_1 = 2'd1, CUR_2 = 2'd2} cursor_t;
  typedef enum logic [1:0] {GRP_NONE = 2'd0, GRP_TIME = 2'd1, GRP_DATE = 2'd2} grp_t;

  // BCD year divisible by 4 <=> (2*tens + units) mod 4 == 0, only tens[0] and units[1:0] matter.
  function automatic logic [7:0] f_daymax(input logic [7:0] mes, input logic [7:0] year);
    logic [1:0] w_mod4;
    w_mod4 = {year[4], 1'b0} + year[1:0];
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: f_daymax = 8'h30;
      8'h02:                      f_daymax = (w_mod4 == 2'b00) ? 8'h29 : 8'h28;
      default:                    f_daymax = 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/contadores_ajuste_contador.sv
// One two-digit BCD field register with load, wrapping inc/dec and clamp to max.
// Update lands one cycle after the request; o_nxt exposes the value being written.
module contador_bcd
  import contadores_ajuste_pkg::*;
#(
  parameter int           N       = 8,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [N-1:0] i_load_val,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clamp,
  input  logic [N-1:0] i_min,
  input  logic [N-1:0] i_max,
  output logic [N-1:0] o_val,
  output logic [N-1:0] o_nxt
);

  localparam logic [N-5:0] HI_ONE  = (N-4)'(1);
  localparam logic [N-5:0] HI_NINE = (N-4)'(9);

  logic [N-1:0] r_val;
  logic [N-1:0] w_nxt;
  logic         w_legal;

  always_comb begin
    w_legal = (r_val[3:0] <= 4'd9) && (r_val[N-1:4] <= HI_NINE) &&
              (r_val >= i_min) && (r_val <= i_max);
    w_nxt   = r_val;
    // An illegal (e.g. loaded out-of-range) value snaps to min on either direction.
    if (i_load) begin
      w_nxt = i_load_val;
    end else if (i_inc) begin
      if (!w_legal || r_val == i_max)  w_nxt = i_min;
      else if (r_val[3:0] == 4'd9)     w_nxt = {r_val[N-1:4] + HI_ONE, 4'd0};
      else                             w_nxt = {r_val[N-1:4], r_val[3:0] + 4'd1};
    end else if (i_dec) begin
      if (!w_legal)                    w_nxt = i_min;
      else if (r_val == i_min)         w_nxt = i_max;
      else if (r_val[3:0] == 4'd0)     w_nxt = {r_val[N-1:4] - HI_ONE, 4'd9};
      else                             w_nxt = {r_val[N-1:4], r_val[3:0] - 4'd1};
    end else if (i_clamp && r_val > i_max) begin
      w_nxt = i_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_val <= RST_VAL;
    else       r_val <= w_nxt;
  end

  assign o_val = r_val;
  assign o_nxt = w_nxt;

endmodule

// File: rtl/contadores_ajuste.sv
// Clock/date/timer field editor: button edges move a cursor and step BCD fields; fields update one cycle after the edge.
// Define DIAS_POR_MES_EN for month/leap-aware day limit with dia clamping; otherwise daymax is fixed at 31.
module contadores_ajuste
  import contadores_ajuste_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         f1,
  input  logic         f2,
  input  logic         f3,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         load,
  input  logic [N-1:0] rtc_hora,
  input  logic [N-1:0] rtc_min,
  input  logic [N-1:0] rtc_seg,
  input  logic [N-1:0] rtc_dia,
  input  logic [N-1:0] rtc_mes,
  input  logic [N-1:0] rtc_year,
  output logic [N-1:0] dato_hora,
  output logic [N-1:0] dato_min,
  output logic [N-1:0] dato_seg,
  output logic [N-1:0] dato_dia,
  output logic [N-1:0] dato_mes,
  output logic [N-1:0] dato_year,
  output logic [1:0]   cursor,
  output logic         cambio
);

  localparam int NF = 6;  // 0 hora, 1 min, 2 seg, 3 dia, 4 mes, 5 year

  grp_t          r_grp, w_grp;
  cursor_t       r_cursor, w_cursor_nxt;
  logic [3:0]    r_btn_q, w_btn, w_edge;
  logic          r_armed, r_cambio;
  logic          w_act, w_up, w_dn, w_left, w_right, w_chg;
  logic [2:0]    w_sel;
  logic [7:0]    w_daymax;
  logic [N-1:0]  w_min [NF];
  logic [N-1:0]  w_max [NF];
  logic [N-1:0]  w_rtc [NF];
  logic [N-1:0]  w_val [NF];
  logic [N-1:0]  w_nxt [NF];
  logic [NF-1:0] w_inc, w_dec, w_clamp;

  // r_armed blocks the first cycle after reset so a button held through reset never fires.
  assign w_btn   = {btn_up, btn_down, btn_left, btn_right};
  assign w_edge  = r_armed ? (w_btn & ~r_btn_q) : 4'b0000;
  assign w_grp   = (f1 | f3) ? GRP_TIME : (f2 ? GRP_DATE : GRP_NONE);
  assign w_act   = (w_grp != GRP_NONE) && (w_grp == r_grp) && !load;
  assign w_up    = w_act && w_edge[3] && !w_edge[2];
  assign w_dn    = w_act && w_edge[2] && !w_edge[3];
  assign w_left  = w_act && w_edge[1] && !w_edge[0];
  assign w_right = w_act && w_edge[0] && !w_edge[1];
  assign w_sel   = ((w_grp == GRP_DATE) ? 3'd3 : 3'd0) + {1'b0, r_cursor};

`ifdef DIAS_POR_MES_EN
  assign w_daymax = f_daymax(w_nxt[4][7:0], w_nxt[5][7:0]);
  assign w_clamp  = {2'b00, (|w_inc[5:4]) | (|w_dec[5:4]), 3'b000};
`else
  assign w_daymax = DIA_MAX;
  assign w_clamp  = '0;
`endif

  assign w_min = '{N'(BCD_ZERO), N'(BCD_ZERO), N'(BCD_ZERO), N'(DIA_MIN), N'(MES_MIN), N'(BCD_ZERO)};
  assign w_max = '{N'(HORA_MAX), N'(MIN_MAX), N'(SEG_MAX), N'(w_daymax), N'(MES_MAX), N'(YEAR_MAX)};
  assign w_rtc = '{rtc_hora, rtc_min, rtc_seg, rtc_dia, rtc_mes, rtc_year};

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_up) w_inc[w_sel] = 1'b1;
    if (w_dn) w_dec[w_sel] = 1'b1;
  end

  always_comb begin
    w_cursor_nxt = r_cursor;
    if (w_grp != r_grp && w_grp != GRP_NONE) begin
      w_cursor_nxt = CUR_0;
    end else if (w_right) begin
      case (r_cursor)
        CUR_0:   w_cursor_nxt = CUR_1;
        CUR_1:   w_cursor_nxt = CUR_2;
        default: w_cursor_nxt = CUR_0;
      endcase
    end else if (w_left) begin
      case (r_cursor)
        CUR_0:   w_cursor_nxt = CUR_2;
        CUR_2:   w_cursor_nxt = CUR_1;
        default: w_cursor_nxt = CUR_0;
      endcase
    end
  end

  always_comb begin
    w_chg = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (w_nxt[i] != w_val[i]) w_chg = 1'b1;
    end
  end

  for (genvar g = 0; g < NF; g++) begin : g_campo
    contador_bcd #(
      .N       (N),
      .RST_VAL ((g == 3 || g == 4) ? N'(DIA_MIN) : N'(BCD_ZERO))
    ) u_campo (
      .clk        (clk),
      .reset      (reset),
      .i_load     (load),
      .i_load_val (w_rtc[g]),
      .i_inc      (w_inc[g]),
      .i_dec      (w_dec[g]),
      .i_clamp    (w_clamp[g]),
      .i_min      (w_min[g]),
      .i_max      (w_max[g]),
      .o_val      (w_val[g]),
      .o_nxt      (w_nxt[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_q  <= 4'b0000;
      r_armed  <= 1'b0;
      r_grp    <= GRP_NONE;
      r_cursor <= CUR_0;
      r_cambio <= 1'b0;
    end else begin
      r_btn_q  <= w_btn;
      r_armed  <= 1'b1;
      r_grp    <= w_grp;
      r_cursor <= w_cursor_nxt;
      r_cambio <= w_chg && !load;
    end
  end

  assign dato_hora = w_val[0];
  assign dato_min  = w_val[1];
  assign dato_seg  = w_val[2];
  assign dato_dia  = w_val[3];
  assign dato_mes  = w_val[4];
  assign dato_year = w_val[5];
  assign cursor    = r_cursor;
  assign cambio    = r_cambio;

endmodule

// File: tb/tb_contadores_ajuste.sv
// Directed bench for contadores_ajuste: each task drives one scenario and checks hand-computed values.
module tb_contadores_ajuste;

  localparam int N = 8;

`ifdef DIAS_POR_MES_EN
  localparam logic [7:0] EXP_FEB23 = 8'h28;
  localparam logic [7:0] EXP_FEB24 = 8'h29;
`else
  localparam logic [7:0] EXP_FEB23 = 8'h31;
  localparam logic [7:0] EXP_FEB24 = 8'h31;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         f1 = 1'b0, f2 = 1'b0, f3 = 1'b0;
  logic         btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] rtc_hora = '0, rtc_min = '0, rtc_seg = '0, rtc_dia = '0, rtc_mes = '0, rtc_year = '0;
  logic [N-1:0] dato_hora, dato_min, dato_seg, dato_dia, dato_mes, dato_year;
  logic [1:0]   cursor;
  logic         cambio;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contadores_ajuste #(.N(N)) dut (
    .clk(clk), .reset(reset), .f1(f1), .f2(f2), .f3(f3),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .load(load),
    .rtc_hora(rtc_hora), .rtc_min(rtc_min), .rtc_seg(rtc_seg),
    .rtc_dia(rtc_dia), .rtc_mes(rtc_mes), .rtc_year(rtc_year),
    .dato_hora(dato_hora), .dato_min(dato_min), .dato_seg(dato_seg),
    .dato_dia(dato_dia), .dato_mes(dato_mes), .dato_year(dato_year),
    .cursor(cursor), .cambio(cambio)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] h, mi, s, d, me, y);
    rtc_hora = h; rtc_min = mi; rtc_seg = s; rtc_dia = d; rtc_mes = me; rtc_year = y;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // 0=up 1=down 2=left 3=right; one full press and release
  task automatic press(input int b);
    case (b)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      default: btn_right = 1'b1;
    endcase
    tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    checks++; if (dato_hora !== 8'h00) begin errors++; $display("FAIL reset_hora: got %h want 00", dato_hora); end
    checks++; if (dato_min !== 8'h00 || dato_seg !== 8'h00) begin errors++; $display("FAIL reset_min_seg: got %h %h want 00 00", dato_min, dato_seg); end
    checks++; if (dato_dia !== 8'h01 || dato_mes !== 8'h01) begin errors++; $display("FAIL reset_dia_mes: got %h %h want 01 01", dato_dia, dato_mes); end
    checks++; if (dato_year !== 8'h00) begin errors++; $display("FAIL reset_year: got %h want 00", dato_year); end
    checks++; if (cursor !== 2'd0 || cambio !== 1'b0) begin errors++; $display("FAIL reset_cursor_cambio: got %0d %b want 0 0", cursor, cambio); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_hora_wrap;
    do_load(8'h23, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00);
    f1 = 1'b1;
    tick();
    checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL t1_cursor: got %0d want 0", cursor); end
    btn_up = 1'b1;
    tick();
    checks++; if (dato_hora !== 8'h00 || cambio !== 1'b1) begin errors++; $display("FAIL t1_hora_wrap: got %h cambio %b want 00 cambio 1", dato_hora, cambio); end
    btn_up = 1'b0;
    tick();
    checks++; if (dato_hora !== 8'h00 || cambio !== 1'b0) begin errors++; $display("FAIL t1_single_pulse: got %h cambio %b want 00 cambio 0", dato_hora, cambio); end
  endtask

  task automatic test_year_held;
    int extra;
    f1 = 1'b0; f2 = 1'b1;
    tick();
    press(3);
    press(3);
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL t2_cursor: got %0d want 2", cursor); end
    btn_down = 1'b1;
    tick();
    checks++; if (dato_year !== 8'h99 || cambio !== 1'b1) begin errors++; $display("FAIL t2_year_wrap: got %h cambio %b want 99 cambio 1", dato_year, cambio); end
    extra = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (cambio === 1'b1) extra++;
    end
    checks++; if (dato_year !== 8'h99 || extra !== 0) begin errors++; $display("FAIL t2_held: got year %h extra pulses %0d want 99 and 0", dato_year, extra); end
    btn_down = 1'b0;
    tick();
  endtask

  task automatic test_dias;
    press(2);
    checks++; if (cursor !== 2'd1) begin errors++; $display("FAIL t3_cursor: got %0d want 1", cursor); end
    do_load(8'h00, 8'h00, 8'h00, 8'h31, 8'h01, 8'h23);
    btn_up = 1'b1;
    tick();
    checks++; if (dato_mes !== 8'h02 || dato_dia !== EXP_FEB23) begin errors++; $display("FAIL t3_feb23: got mes %h dia %h want 02 %h", dato_mes, dato_dia, EXP_FEB23); end
    btn_up = 1'b0;
    tick();
    do_load(8'h00, 8'h00, 8'h00, 8'h31, 8'h01, 8'h24);
    press(0);
    checks++; if (dato_mes !== 8'h02 || dato_dia !== EXP_FEB24) begin errors++; $display("FAIL t3_feb24: got mes %h dia %h want 02 %h", dato_mes, dato_dia, EXP_FEB24); end
    press(2);
    press(0);
    checks++; if (dato_dia !== 8'h01) begin errors++; $display("FAIL t3_dia_wrap: got %h want 01", dato_dia); end
    press(3);
    do_load(8'h00, 8'h00, 8'h00, 8'h10, 8'h15, 8'h00);
    btn_up = 1'b1;
    tick();
    checks++; if (dato_mes !== 8'h01 || dato_dia !== 8'h10 || cambio !== 1'b1) begin errors++; $display("FAIL t3_mes_illegal: got mes %h dia %h cambio %b want 01 10 1", dato_mes, dato_dia, cambio); end
    btn_up = 1'b0;
    tick();
    press(1);
    checks++; if (dato_mes !== 8'h12) begin errors++; $display("FAIL t3_mes_underflow: got %h want 12", dato_mes); end
  endtask

  task automatic test_load_priority;
    f2 = 1'b0; f1 = 1'b1;
    tick();
    rtc_hora = 8'h15; rtc_min = 8'h00; rtc_seg = 8'h00; rtc_dia = 8'h01; rtc_mes = 8'h01; rtc_year = 8'h42;
    load = 1'b1; btn_up = 1'b1;
    tick();
    checks++; if (dato_hora !== 8'h15 || cambio !== 1'b0) begin errors++; $display("FAIL t4_load: got %h cambio %b want 15 cambio 0", dato_hora, cambio); end
    load = 1'b0;
    tick();
    checks++; if (dato_hora !== 8'h15 || cambio !== 1'b0) begin errors++; $display("FAIL t4_held_after_load: got %h cambio %b want 15 cambio 0", dato_hora, cambio); end
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1; btn_down = 1'b1;
    tick();
    checks++; if (dato_hora !== 8'h15 || cambio !== 1'b0) begin errors++; $display("FAIL t4_up_and_down: got %h cambio %b want 15 cambio 0", dato_hora, cambio); end
    btn_up = 1'b0; btn_down = 1'b0;
    tick();
    press(3);
    do_load(8'h15, 8'h59, 8'h00, 8'h01, 8'h01, 8'h42);
    btn_up = 1'b1;
    tick();
    checks++; if (dato_min !== 8'h00 || cambio !== 1'b1) begin errors++; $display("FAIL t4_min_wrap: got %h cambio %b want 00 cambio 1", dato_min, cambio); end
    btn_up = 1'b0;
    tick();
    press(1);
    checks++; if (dato_min !== 8'h59) begin errors++; $display("FAIL t4_min_underflow: got %h want 59", dato_min); end
  endtask

  task automatic test_cursor;
    press(3);
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL t5_right: got %0d want 2", cursor); end
    f1 = 1'b0; f2 = 1'b1;
    tick();
    checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL t5_group_switch: got %0d want 0", cursor); end
    press(2);
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL t5_left_wrap: got %0d want 2", cursor); end
    f2 = 1'b0;
    tick();
    press(3);
    checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL t5_no_group_cursor: got %0d want 2", cursor); end
    btn_up = 1'b1;
    tick();
    checks++; if (cambio !== 1'b0 || dato_year !== 8'h42 || dato_hora !== 8'h15) begin errors++; $display("FAIL t5_no_group_up: got cambio %b year %h hora %h want 0 42 15", cambio, dato_year, dato_hora); end
    btn_up = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    f1 = 1'b1;
    tick();
    checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL t6_cursor: got %0d want 0", cursor); end
    do_load(8'h05, 8'h30, 8'h30, 8'h15, 8'h06, 8'h50);
    btn_up = 1'b1;
    #3 reset = 1'b1;
    #1;
    checks++; if (dato_hora !== 8'h00 || dato_min !== 8'h00 || dato_dia !== 8'h01 || dato_year !== 8'h00) begin errors++; $display("FAIL t6_async: got %h %h %h %h want 00 00 01 00", dato_hora, dato_min, dato_dia, dato_year); end
    tick(2);
    reset = 1'b0;
    tick(3);
    checks++; if (dato_hora !== 8'h00 || cambio !== 1'b0) begin errors++; $display("FAIL t6_held_release: got %h cambio %b want 00 cambio 0", dato_hora, cambio); end
    btn_up = 1'b0;
    tick();
    btn_up = 1'b1;
    tick();
    checks++; if (dato_hora !== 8'h01 || cambio !== 1'b1) begin errors++; $display("FAIL t6_new_edge: got %h cambio %b want 01 cambio 1", dato_hora, cambio); end
    btn_up = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_hora_wrap();
    test_year_held();
    test_dias();
    test_load_priority();
    test_cursor();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
